// File: rtl/dht11_pkg.sv
// Shared types and protocol timing for the DHT11 responder.
// Durations are in microseconds; the frame is 4 data bytes plus a checksum.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_WAIT_REL,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW
  } state_t;

  localparam int T_WAIT_REL  = 30;
  localparam int T_RESP      = 80;
  localparam int T_BIT_LOW   = 50;
  localparam int T_BIT0_HIGH = 26;
  localparam int T_BIT1_HIGH = 70;
  localparam int T_END       = 50;
  localparam int FRAME_BITS  = 40;

  function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

  // States in which the responder holds the line low.
  function automatic logic drive_for(input state_t s);
    return (s == ST_RESP_LOW) || (s == ST_BIT_LOW) || (s == ST_END_LOW);
  endfunction

endpackage

// File: rtl/dht11_responder_if.sv
// Single-wire line plus sensor data bytes and frame status.
interface dht11_responder_if;
  logic       dq_in;
  logic       dq_drive_low;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       busy;
  logic       frame_done;

  modport master (
    output dq_in, hum_int, hum_dec, temp_int, temp_dec,
    input  dq_drive_low, busy, frame_done
  );

  modport slave (
    input  dq_in, hum_int, hum_dec, temp_int, temp_dec,
    output dq_drive_low, busy, frame_done
  );
endinterface

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler: tick pulses on the last clk of each TICK_DIV-cycle period.
module dht11_us_tick #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_reg <= '0;
    else if (clr || cnt_reg == TC)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + 1'b1;
  end

  assign tick = (cnt_reg == TC);
endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: waits for a long host low pulse, then answers with the
// presence handshake and a 40-bit MSB-first frame ending in a byte checksum.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int TICK_DIV     = 50,
  parameter int START_MIN_US = 18000
) (
  input  logic               clk,
  input  logic               reset,
  dht11_responder_if.slave   bus
);
  localparam int US_W = $clog2(START_MIN_US + 128);
  localparam logic [US_W-1:0] START_MIN = US_W'(START_MIN_US);

  state_t                  state_reg, state_next;
  logic                    dq_meta_reg, dq_s_reg;
  logic                    armed_reg;
  logic [US_W-1:0]         us_cnt_reg;
  logic [5:0]              bit_idx_reg;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic                    drive_reg, busy_reg, done_reg;
  logic                    tick, clr;
  logic                    accept, bit_done, release_now;
  logic [US_W-1:0]         phase_len;
  logic                    phase_end;

  dht11_us_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dq_meta_reg <= 1'b1;
      dq_s_reg    <= 1'b1;
    end else begin
      dq_meta_reg <= bus.dq_in;
      dq_s_reg    <= dq_meta_reg;
    end
  end

  always_comb begin
    phase_len = '0;
    case (state_reg)
      ST_WAIT_REL:  phase_len = US_W'(T_WAIT_REL);
      ST_RESP_LOW,
      ST_RESP_HIGH: phase_len = US_W'(T_RESP);
      ST_BIT_LOW:   phase_len = US_W'(T_BIT_LOW);
      ST_BIT_HIGH:  phase_len = shift_reg[FRAME_BITS-1] ? US_W'(T_BIT1_HIGH) : US_W'(T_BIT0_HIGH);
      ST_END_LOW:   phase_len = US_W'(T_END);
      default:      phase_len = '0;
    endcase
    phase_end = tick && (us_cnt_reg == phase_len - 1'b1);
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    bit_done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Arming requires the line to have been seen high first, so a line
        // left low at frame end does not look like a fresh start pulse.
        if (armed_reg && !dq_s_reg)
          state_next = ST_HOST_LOW;
      end
      ST_HOST_LOW: begin
        if (dq_s_reg) begin
          if (us_cnt_reg >= START_MIN) begin
            state_next = ST_WAIT_REL;
            accept     = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_WAIT_REL:  if (phase_end) state_next = ST_RESP_LOW;
      ST_RESP_LOW:  if (phase_end) state_next = ST_RESP_HIGH;
      ST_RESP_HIGH: if (phase_end) state_next = ST_BIT_LOW;
      ST_BIT_LOW:   if (phase_end) state_next = ST_BIT_HIGH;
      ST_BIT_HIGH: begin
        if (phase_end) begin
          bit_done   = 1'b1;
          state_next = (bit_idx_reg == 6'(FRAME_BITS - 1)) ? ST_END_LOW : ST_BIT_LOW;
        end
      end
      ST_END_LOW:   if (phase_end) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  assign clr         = (state_next != state_reg);
  assign release_now = (state_reg == ST_IDLE) && drive_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      armed_reg   <= 1'b0;
      us_cnt_reg  <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      drive_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      armed_reg <= (state_reg == ST_IDLE) ? (armed_reg | dq_s_reg) : 1'b0;

      if (clr)
        us_cnt_reg <= '0;
      else if (tick && !(state_reg == ST_HOST_LOW && us_cnt_reg == START_MIN))
        us_cnt_reg <= us_cnt_reg + 1'b1;

      if (accept) begin
        shift_reg   <= {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec,
                        checksum(bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec)};
        bit_idx_reg <= '0;
      end else if (bit_done) begin
        shift_reg   <= {shift_reg[FRAME_BITS-2:0], 1'b0};
        bit_idx_reg <= bit_idx_reg + 1'b1;
      end

      // The line output lags the state by one cycle; frame_done and the busy
      // drop are aligned with that lagged release rather than the state change.
      drive_reg <= drive_for(state_reg);
      done_reg  <= release_now;
      if (accept)
        busy_reg <= 1'b1;
      else if (release_now)
        busy_reg <= 1'b0;
    end
  end

  assign bus.dq_drive_low = drive_reg;
  assign bus.busy         = busy_reg;
  assign bus.frame_done   = done_reg;
endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench: emulates the host and the open-drain line, decodes the responder's pulses.
module tb_dht11_responder;
  localparam int TICK_DIV     = 2;
  localparam int START_MIN_US = 100;
  // Release sample + 2 sync flops + state register + output register around 30 us.
  localparam int EXP_GAP      = 30 * TICK_DIV + 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic host_low = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   fd_count = 0;
  int   rise_cnt = 0;
  logic drive_prev = 1'b0;

  always #5 clk = ~clk;

  dht11_responder_if bus_if ();
  assign bus_if.dq_in = ~(host_low | bus_if.dq_drive_low);

  dht11_responder #(.TICK_DIV(TICK_DIV), .START_MIN_US(START_MIN_US)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always @(negedge clk) begin
    drive_prev <= bus_if.dq_drive_low;
    if (bus_if.dq_drive_low && !drive_prev) rise_cnt <= rise_cnt + 1;
    if (bus_if.frame_done) fd_count <= fd_count + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    bus_if.hum_int  = a;
    bus_if.hum_dec  = b;
    bus_if.temp_int = c;
    bus_if.temp_dec = d;
  endtask

  task automatic host_start(input int cycles);
    @(negedge clk);
    host_low = 1'b1;
    repeat (cycles) @(negedge clk);
    host_low = 1'b0;
  endtask

  // Counts consecutive negedge samples (starting now) at the given level.
  task automatic measure(input logic level, output int len);
    len = 0;
    while (bus_if.dq_drive_low === level && len < 400) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic decode_frame(output logic [39:0] d, output int bad,
                              output int gap, output logic busy_mid);
    int len;
    bad = 0;
    d   = '0;
    measure(1'b0, gap);
    busy_mid = bus_if.busy;
    measure(1'b1, len); if (len != 160) bad++;
    measure(1'b0, len); if (len != 160) bad++;
    for (int i = 0; i < 40; i++) begin
      measure(1'b1, len); if (len != 100) bad++;
      measure(1'b0, len);
      if (len == 140)     d = {d[38:0], 1'b1};
      else if (len == 52) d = {d[38:0], 1'b0};
      else begin
        bad++;
        d = {d[38:0], 1'b0};
      end
    end
    measure(1'b1, len); if (len != 100) bad++;
  endtask

  task automatic test_reset();
    int viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      host_low = ~host_low;
      if (bus_if.dq_drive_low !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.frame_done !== 1'b0) viol++;
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL reset_hold: %0d bad samples, required 0", viol); end
    @(negedge clk);
    host_low = 1'b0;
    reset = 1'b1;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_if.dq_drive_low !== 1'b0 || bus_if.busy !== 1'b0) viol++;
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL reset_idle: %0d active samples, required 0", viol); end
    $display("reset: hold and post-release idle checked");
  endtask

  task automatic test_valid_start();
    logic [39:0] d;
    int bad, gap, fd0;
    logic bm;
    set_bytes(8'h37, 8'h00, 8'h18, 8'h05);
    fd0 = fd_count;
    host_start(220);
    decode_frame(d, bad, gap, bm);
    n_checks++;
    if (gap !== EXP_GAP) begin n_fail++; $display("FAIL valid_gap: got %0d required %0d", gap, EXP_GAP); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL valid_timing: %0d bad intervals, required 0", bad); end
    n_checks++;
    if (d !== 40'h37_00_18_05_54) begin n_fail++; $display("FAIL valid_data: got %h required 3700180554", d); end
    n_checks++;
    if (bm !== 1'b1) begin n_fail++; $display("FAIL valid_busy_mid: got %b required 1", bm); end
    n_checks++;
    if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL valid_busy_end: got %b required 0", bus_if.busy); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (fd_count !== fd0 + 1) begin n_fail++; $display("FAIL valid_frame_done: got %0d pulses required 1", fd_count - fd0); end
    $display("valid: frame %h gap %0d", d, gap);
  endtask

  task automatic test_short_start();
    int viol = 0;
    host_start(150);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_if.dq_drive_low !== 1'b0 || bus_if.busy !== 1'b0) viol++;
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL short_start: %0d active samples, required 0", viol); end
    $display("short: 150-cycle low rejected");
  endtask

  task automatic test_checksum_wrap();
    logic [39:0] d;
    int bad, gap;
    logic bm;
    set_bytes(8'hFF, 8'hFF, 8'h01, 8'h02);
    host_start(220);
    decode_frame(d, bad, gap, bm);
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL wrap_timing: %0d bad intervals, required 0", bad); end
    n_checks++;
    if (d !== 40'hFF_FF_01_02_01) begin n_fail++; $display("FAIL wrap_data: got %h required ffff010201", d); end
    $display("wrap: frame %h", d);
  endtask

  task automatic test_disturb();
    logic [39:0] d;
    int bad, gap, base, viol;
    logic bm;
    set_bytes(8'h12, 8'h34, 8'h56, 8'h78);
    @(negedge clk);
    base = rise_cnt;
    host_start(220);
    fork
      decode_frame(d, bad, gap, bm);
      begin
        for (int k = 0; k < 20000 && rise_cnt < base + 12; k++) @(negedge clk);
        for (int k = 0; k < 400 && bus_if.dq_drive_low !== 1'b0; k++) @(negedge clk);
        set_bytes(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        host_low = 1'b1;
        repeat (20) @(negedge clk);
        host_low = 1'b0;
      end
    join
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL disturb_timing: %0d bad intervals, required 0", bad); end
    n_checks++;
    if (d !== 40'h12_34_56_78_14) begin n_fail++; $display("FAIL disturb_data: got %h required 1234567814", d); end
    viol = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_if.dq_drive_low !== 1'b0 || bus_if.busy !== 1'b0) viol++;
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL disturb_restart: %0d active samples, required 0", viol); end
    $display("disturb: frame %h", d);
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] d;
    int bad, gap, base, fd0, viol;
    logic bm;
    set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
    @(negedge clk);
    base = rise_cnt;
    fd0  = fd_count;
    host_start(220);
    for (int k = 0; k < 20000 && rise_cnt < base + 22; k++) @(negedge clk);
    n_checks++;
    if (rise_cnt < base + 22) begin n_fail++; $display("FAIL rst_reach_bit20: got %0d rises required %0d", rise_cnt - base, 22); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus_if.dq_drive_low !== 1'b0) begin n_fail++; $display("FAIL rst_release: got %b required 0", bus_if.dq_drive_low); end
    n_checks++;
    if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", bus_if.busy); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    viol = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_if.dq_drive_low !== 1'b0) viol++;
    end
    n_checks++;
    if (fd_count !== fd0 || viol !== 0) begin
      n_fail++;
      $display("FAIL rst_discard: got %0d pulses %0d active samples, required 0 0", fd_count - fd0, viol);
    end
    set_bytes(8'h40, 8'h30, 8'h20, 8'h10);
    fd0 = fd_count;
    host_start(220);
    decode_frame(d, bad, gap, bm);
    repeat (3) @(negedge clk);
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL recover_timing: %0d bad intervals, required 0", bad); end
    n_checks++;
    if (d !== 40'h40_30_20_10_A0) begin n_fail++; $display("FAIL recover_data: got %h required 40302010a0", d); end
    n_checks++;
    if (fd_count !== fd0 + 1) begin n_fail++; $display("FAIL recover_frame_done: got %0d pulses required 1", fd_count - fd0); end
    $display("reset_mid: aborted, recovery frame %h", d);
  endtask

  task automatic test_back_to_back();
    logic [39:0] d1, d2;
    int bad1, bad2, gap;
    logic bm;
    set_bytes(8'h01, 8'h02, 8'h03, 8'h04);
    host_start(220);
    decode_frame(d1, bad1, gap, bm);
    repeat (9) @(negedge clk);
    set_bytes(8'hA5, 8'h5A, 8'h0F, 8'hF0);
    host_start(220);
    decode_frame(d2, bad2, gap, bm);
    n_checks++;
    if (bad1 !== 0 || bad2 !== 0) begin n_fail++; $display("FAIL b2b_timing: %0d/%0d bad intervals, required 0/0", bad1, bad2); end
    n_checks++;
    if (d1 !== 40'h01_02_03_04_0A) begin n_fail++; $display("FAIL b2b_first: got %h required 010203040a", d1); end
    n_checks++;
    if (d2 !== 40'hA5_5A_0F_F0_FE) begin n_fail++; $display("FAIL b2b_second: got %h required a55a0ff0fe", d2); end
    $display("b2b: frames %h %h", d1, d2);
  endtask

  initial begin
    set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_valid_start();
    test_short_start();
    test_checksum_wrap();
    test_disturb();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
